// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// The clog2 helper sizes the grant index and beat counter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_DATA_LEN  = 32;
   localparam int DEF_MAX_BURST = 8;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Rotate-priority encoder: returns the first set request at or above start_i,
// wrapping modulo NUM_REQ.
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_LEN  = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_LEN-1:0]  start_i,
   output logic [ID_LEN-1:0]  pick_o,
   output logic               any_valid_o
);

   logic [2*NUM_REQ-1:0] rot;
   logic                 found;
   int                   off;
   int                   sum;

   always_comb begin
      rot   = {req_i, req_i} >> start_i;
      found = 1'b0;
      off   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            off   = k;
         end
      end
      // explicit modulo so non-power-of-two NUM_REQ wraps correctly
      sum = int'(start_i) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      pick_o = ID_LEN'(sum);
   end

   assign any_valid_o = |req_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port between
// NUM_REQ requesters; every write is gated by the FIFO full flag.
//
// state | meaning
// IDLE  | no grant; picker chooses next requester from rr_ptr
// BURST | grant_id owns the port until last or MAX_BURST beats
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int DATA_LEN  = DEF_DATA_LEN,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ-1:0]           req_last,
   input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic                         fifo_full,
   output logic                         fifo_write_en,
   output logic [DATA_LEN-1:0]          fifo_wdata,
   output logic [clog2(NUM_REQ)-1:0]    grant_id,
   output logic                         busy
);

   localparam int ID_LEN  = clog2(NUM_REQ);
   localparam int CNT_LEN = clog2(MAX_BURST + 1);
   localparam logic [CNT_LEN-1:0] LAST_CNT = CNT_LEN'(MAX_BURST - 1);
   localparam logic [ID_LEN-1:0]  LAST_ID  = ID_LEN'(NUM_REQ - 1);

   arb_state_e          state_q;
   logic [ID_LEN-1:0]   rr_ptr_q;
   logic [ID_LEN-1:0]   rr_ptr_d;
   logic [ID_LEN-1:0]   grant_q;
   logic [CNT_LEN-1:0]  beat_cnt_q;
   logic [ID_LEN-1:0]   pick;
   logic                any_valid;
   logic                in_burst;
   logic                wr_en;
   logic                burst_end;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_LEN  (ID_LEN)
   ) u_picker (
      .req_i       (req_valid),
      .start_i     (rr_ptr_q),
      .pick_o      (pick),
      .any_valid_o (any_valid)
   );

   assign in_burst  = (state_q == BURST);
   // rst gates the port combinationally so an abort writes nothing more
   assign wr_en     = in_burst && !rst && !fifo_full && req_valid[grant_q];
   assign burst_end = req_last[grant_q] || (beat_cnt_q == LAST_CNT);
   assign rr_ptr_d  = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;

   assign req_ready     = (in_burst && !rst && !fifo_full) ?
                          (NUM_REQ'(1) << grant_q) : '0;
   assign fifo_write_en = wr_en;
   assign fifo_wdata    = in_burst ? req_data[int'(grant_q)*DATA_LEN +: DATA_LEN] : '0;
   assign grant_id      = grant_q;
   assign busy          = in_burst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_valid) begin
                  grant_q    <= pick;
                  beat_cnt_q <= '0;
                  state_q    <= BURST;
               end
            end
            BURST: begin
               if (wr_en) begin
                  if (burst_end) begin
                     state_q    <= IDLE;
                     rr_ptr_q   <= rr_ptr_d;
                     beat_cnt_q <= '0;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
